// File: rtl/global_pkg.sv
// global_pkg: shared UART receiver state encoding and default line-rate constants
package global_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} uart_rx_state_t;
   localparam logic [31:0] DEF_FREQ_CLK = 32'd100_000_000;
   localparam logic [31:0] DEF_TX_SPEED = 32'd115_200;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous input, reset value selectable
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta;
   // shift the raw input through two flops to settle metastability
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {q, meta} <= {2{RST_VAL}};
      else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with Valid/Ack holding register; define UART_RX_PARITY_EN for 8E1
module uart_rx
   import global_pkg::*;
#(
   parameter logic [31:0] FREQ_CLK = DEF_FREQ_CLK,
   parameter logic [31:0] TX_SPEED = DEF_TX_SPEED
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       RXD,
   output logic [7:0] Data,
   output logic       Valid,
   input  logic       Ack,
   output logic       Busy,
   output logic       Frame_Err,
`ifdef UART_RX_PARITY_EN
   output logic       Parity_Err,
`endif
   output logic       Overrun
);
   localparam logic [31:0] BIT_CYCLES = FREQ_CLK / TX_SPEED;
   localparam int CW = $clog2(BIT_CYCLES);
   localparam logic [CW-1:0] FULL = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2 - 1);
   uart_rx_state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0] idx, idx_n;
   logic [7:0] shift, shift_n;
   logic rxd_s, expd, stop_hit, commit, par_bad;
   sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(Clk), .rst_n(Rst_n), .d(RXD), .q(rxd_s));
   assign expd = cnt == '0;
   assign Busy = state != IDLE;
   assign stop_hit = state == STOP && expd;
   assign commit = stop_hit && rxd_s && !par_bad;
`ifdef UART_RX_PARITY_EN
   logic perr;
   assign par_bad = perr;
   // latch the parity verdict so it is reported together with the stop sample
   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) begin
         perr <= 1'b0;
         Parity_Err <= 1'b0;
      end else begin
         if (state == PARITY && expd) perr <= rxd_s ^ (^shift);
         Parity_Err <= stop_hit && perr;
      end
`else
   assign par_bad = 1'b0;
`endif
   // frame sequencing: start qualification, mid-bit data sampling, stop check
   always_comb begin
      state_n = state;
      cnt_n = expd ? cnt : cnt - 1'b1;
      idx_n = idx;
      shift_n = shift;
      case (state)
         IDLE: if (!rxd_s) begin
            state_n = START;
            cnt_n = HALF;
         end
         START: if (expd) begin
            state_n = rxd_s ? IDLE : DATA;
            cnt_n = FULL;
            idx_n = '0;
         end
         DATA: if (expd) begin
            shift_n = {rxd_s, shift[7:1]};
            cnt_n = FULL;
            idx_n = idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (idx == 3'd7) state_n = PARITY;
`else
            if (idx == 3'd7) state_n = STOP;
`endif
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (expd) begin
            state_n = STOP;
            cnt_n = FULL;
         end
`endif
         STOP: if (expd) state_n = rxd_s ? IDLE : BREAK;
         BREAK: if (rxd_s) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   // state, datapath and holding register; a byte arriving while unacked is dropped
   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) begin
         state <= IDLE;
         cnt <= '0;
         idx <= '0;
         shift <= '0;
         Data <= '0;
         Valid <= 1'b0;
         Frame_Err <= 1'b0;
         Overrun <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         idx <= idx_n;
         shift <= shift_n;
         if (commit && (!Valid || Ack)) begin
            Data <= shift;
            Valid <= 1'b1;
         end else if (Ack) Valid <= 1'b0;
         Frame_Err <= stop_hit && !rxd_s;
         Overrun <= commit && Valid && !Ack;
      end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx (UART_RX_PARITY_EN adds the parity case)
module tb_uart_rx;
   import global_pkg::*;
   localparam int BIT = int'(DEF_FREQ_CLK / DEF_TX_SPEED);
`ifdef UART_RX_PARITY_EN
   localparam int PAR = 1;
   logic Parity_Err;
   int pe_cnt = 0;
`else
   localparam int PAR = 0;
`endif
   localparam int LAT = 2 + BIT / 2 + (9 + PAR) * BIT + 1;
   logic Clk = 1'b0, Rst_n = 1'b1, RXD = 1'b1, Ack = 1'b0;
   logic Valid, Busy, Frame_Err, Overrun;
   logic [7:0] Data;
   logic [7:0] sb[$];
   logic prev_valid = 1'b0, prev_ack = 1'b0;
   int n_cmp = 0, n_err = 0, cyc = 0, fe_cnt = 0, ov_cnt = 0, t0 = 0, tv = 0, ack_mode = 0;
   uart_rx dut (
      .Clk(Clk), .Rst_n(Rst_n), .RXD(RXD), .Data(Data), .Valid(Valid), .Ack(Ack),
      .Busy(Busy), .Frame_Err(Frame_Err),
`ifdef UART_RX_PARITY_EN
      .Parity_Err(Parity_Err),
`endif
      .Overrun(Overrun));
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask
   task automatic cycles(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask
   task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1, input logic odd = 1'b0);
      RXD = 1'b0;
      cycles(BIT);
      for (int i = 0; i < 8; i++) begin
         RXD = b[i];
         cycles(BIT);
      end
      if (PAR == 1) begin
         RXD = (^b) ^ odd;
         cycles(BIT);
      end
      RXD = stop_bit;
      cycles(BIT);
   endtask
   // acknowledge policy: 0 never, 1 always, 2 one cycle after Valid
   initial forever begin
      @(posedge Clk);
      #1;
      Ack = ack_mode == 1 ? 1'b1 : ack_mode == 2 ? Valid : 1'b0;
   end
   // monitor: count flag pulses and check every newly presented byte against the scoreboard
   always @(negedge Clk) begin
      if (Frame_Err) fe_cnt++;
      if (Overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
      if (Parity_Err) pe_cnt++;
`endif
      if (Valid && (!prev_valid || prev_ack)) begin
         tv = cyc;
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_byte: got Data=%0h, required no byte", Data);
         end else chk("rx_data", {24'd0, Data}, {24'd0, sb.pop_front()});
      end
      prev_valid = Valid;
      prev_ack = Ack;
   end
   initial begin
      logic [7:0] f = 8'hF0;
      #1 Rst_n = 1'b0;
      #1;
      chk("rst_data", {24'd0, Data}, 0);
      chk("rst_valid", {31'd0, Valid}, 0);
      chk("rst_busy", {31'd0, Busy}, 0);
      chk("rst_ferr", {31'd0, Frame_Err}, 0);
      chk("rst_ovr", {31'd0, Overrun}, 0);
      cycles(3);
      Rst_n = 1'b1;
      ack_mode = 1;
      cycles(5);
      sb.push_back(8'hAB);
      t0 = cyc;
      send_byte(8'hAB);
      cycles(20);
      n_cmp++;
      if (tv - t0 < LAT - 1 || tv - t0 > LAT + 1) begin
         n_err++;
         $display("FAIL latency: got %0d cycles, required %0d +-1", tv - t0, LAT);
      end
      chk("single_ferr", fe_cnt, 0);
      chk("single_ovr", ov_cnt, 0);
      ack_mode = 2;
      sb.push_back(8'hAB);
      sb.push_back(8'hCD);
      send_byte(8'hAB);
      send_byte(8'hCD);
      cycles(20);
      chk("b2b_valid", {31'd0, Valid}, 0);
      chk("b2b_ferr", fe_cnt, 0);
      chk("b2b_ovr", ov_cnt, 0);
      ack_mode = 1;
      RXD = 1'b0;
      cycles(100);
      chk("glitch_busy_hi", {31'd0, Busy}, 1);
      cycles(100);
      RXD = 1'b1;
      cycles(260);
      chk("glitch_busy_lo", {31'd0, Busy}, 0);
      chk("glitch_valid", {31'd0, Valid}, 0);
      send_byte(8'h55, 1'b0);
      cycles(2000);
      chk("ferr_pulse", fe_cnt, 1);
      chk("ferr_busy", {31'd0, Busy}, 1);
      chk("ferr_valid", {31'd0, Valid}, 0);
      RXD = 1'b1;
      cycles(5);
      chk("ferr_idle", {31'd0, Busy}, 0);
      ack_mode = 0;
      cycles(2);
      sb.push_back(8'h12);
      send_byte(8'h12);
      send_byte(8'h34);
      cycles(20);
      chk("ovr_pulse", ov_cnt, 1);
      chk("ovr_data", {24'd0, Data}, 32'h12);
      chk("ovr_valid", {31'd0, Valid}, 1);
      RXD = 1'b0;
      cycles(BIT);
      for (int i = 0; i < 5; i++) begin
         RXD = f[i];
         cycles(i == 4 ? BIT / 2 : BIT);
      end
      Rst_n = 1'b0;
      #1;
      chk("mid_rst_data", {24'd0, Data}, 0);
      chk("mid_rst_valid", {31'd0, Valid}, 0);
      chk("mid_rst_busy", {31'd0, Busy}, 0);
      chk("mid_rst_flags", {30'd0, Frame_Err, Overrun}, 0);
      cycles(3);
      Rst_n = 1'b1;
      ack_mode = 1;
      cycles(10);
      sb.push_back(8'hA5);
      send_byte(8'hA5);
      cycles(20);
      chk("post_rst_ferr", fe_cnt, 1);
      chk("post_rst_ovr", ov_cnt, 1);
`ifdef UART_RX_PARITY_EN
      chk("par_none", pe_cnt, 0);
      send_byte(8'hA5, 1'b1, 1'b1);
      cycles(20);
      chk("par_pulse", pe_cnt, 1);
      chk("par_valid", {31'd0, Valid}, 0);
`endif
      chk("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
